// File: rtl/fft_pkg.sv
// Shared definitions for the fft_burst datapath: default frame geometry and
// the peak-detector FSM state encoding.
package fft_pkg;

    localparam int FFT_DATA_W    = 16;
    localparam int FFT_FRAME_LEN = 1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } fft_state_t;

endpackage

// File: rtl/fft_mag_sq.sv
// Two-stage registered squared magnitude (re^2 + im^2) with a valid bit and
// an opaque sideband that travels alongside the data.
module fft_mag_sq #(
    parameter int DATA_W = 16,
    parameter int SB_W   = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic signed [DATA_W-1:0]   in_real,
    input  logic signed [DATA_W-1:0]   in_imag,
    input  logic [SB_W-1:0]            in_sb,
    output logic                       out_valid,
    output logic [2*DATA_W:0]          out_mag,
    output logic [SB_W-1:0]            out_sb
);

    // Full-width signed products so that (-2^(DATA_W-1))^2 is exact
    logic signed [2*DATA_W-1:0] re_prod;
    logic signed [2*DATA_W-1:0] im_prod;

    logic                  s1_valid;
    logic [2*DATA_W-1:0]   s1_re_sq;
    logic [2*DATA_W-1:0]   s1_im_sq;
    logic [SB_W-1:0]       s1_sb;

    assign re_prod = in_real * in_real;
    assign im_prod = in_imag * in_imag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_re_sq  <= '0;
            s1_im_sq  <= '0;
            s1_sb     <= '0;
            out_valid <= 1'b0;
            out_mag   <= '0;
            out_sb    <= '0;
        end else begin
            s1_valid  <= in_valid;
            s1_re_sq  <= re_prod;
            s1_im_sq  <= im_prod;
            s1_sb     <= in_sb;
            out_valid <= s1_valid;
            out_mag   <= {1'b0, s1_re_sq} + {1'b0, s1_im_sq};
            out_sb    <= s1_sb;
        end
    end

endmodule

// File: rtl/fft_peak_detect.sv
// Frames the FFT source stream, squares each bin and reports the largest bin
// in the search window after every well-formed frame.
module fft_peak_detect
    import fft_pkg::*;
#(
    parameter int DATA_W    = FFT_DATA_W,
    parameter int FRAME_LEN = FFT_FRAME_LEN,
    parameter int IDX_W     = $clog2(FRAME_LEN),
    parameter int SEARCH_LO = 1,
    parameter int SEARCH_HI = FRAME_LEN/2-1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     source_valid,
    input  logic                     source_sop,
    input  logic                     source_eop,
    input  logic signed [DATA_W-1:0] source_real,
    input  logic signed [DATA_W-1:0] source_imag,
    output logic                     source_ready,
    output logic [IDX_W-1:0]         peak_idx,
    output logic [2*DATA_W:0]        peak_mag,
    output logic                     peak_valid,
    output logic                     frame_err
);

    localparam int MAG_W = 2*DATA_W+1;
    localparam int SB_W  = IDX_W+2;
    localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(FRAME_LEN-1);
    localparam logic [IDX_W-1:0] LO_BIN   = IDX_W'(SEARCH_LO);
    localparam logic [IDX_W-1:0] HI_BIN   = IDX_W'(SEARCH_HI);

    fft_state_t        state, state_n;
    logic [IDX_W-1:0]  cnt, cnt_n;
    logic              pending, pend_n;
    logic              ready_r;

    logic              beat, active, drop;
    logic              accept, first_c, last_c, err_c;
    logic [IDX_W-1:0]  bin_c;

    logic                     in_valid_r;
    logic signed [DATA_W-1:0] in_real_r;
    logic signed [DATA_W-1:0] in_imag_r;
    logic [SB_W-1:0]          in_sb_r;

    logic              mq_valid;
    logic [MAG_W-1:0]  mq_mag;
    logic [SB_W-1:0]   mq_sb;
    logic              mq_first, mq_last;
    logic [IDX_W-1:0]  mq_idx;

    logic [MAG_W-1:0]  max_mag, base_mag, cand_mag;
    logic [IDX_W-1:0]  max_idx, base_idx, cand_idx;
    logic              last_r;

    assign source_ready = ready_r;
    assign beat         = source_valid && ready_r;

    // A sop seen in REPORT opens the next frame early (pending) so that the
    // frame tracker keeps counting while the previous result drains.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pend_n  = pending;
        accept  = 1'b0;
        first_c = 1'b0;
        last_c  = 1'b0;
        err_c   = 1'b0;
        drop    = 1'b0;
        bin_c   = cnt;
        active  = (state == RUN) || ((state == REPORT) && pending);
        if (beat) begin
            if (source_sop) begin
                accept  = 1'b1;
                first_c = 1'b1;
                bin_c   = '0;
                cnt_n   = IDX_W'(1);
                err_c   = active;
                if (state == REPORT) pend_n = 1'b1;
                else                 state_n = RUN;
            end else if (active) begin
                accept = 1'b1;
                cnt_n  = cnt + 1'b1;
                if (source_eop && (cnt == LAST_BIN)) begin
                    last_c  = 1'b1;
                    cnt_n   = '0;
                    state_n = REPORT;
                    pend_n  = 1'b0;
                end else if (source_eop || (cnt == LAST_BIN)) begin
                    err_c = 1'b1;
                    cnt_n = '0;
                    drop  = 1'b1;
                end
            end
        end
        if (drop) begin
            if (state == REPORT) pend_n = 1'b0;
            else                 state_n = IDLE;
        end
        if ((state == REPORT) && last_r) state_n = pend_n ? RUN : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            pending    <= 1'b0;
            ready_r    <= 1'b0;
            frame_err  <= 1'b0;
            in_valid_r <= 1'b0;
            in_real_r  <= '0;
            in_imag_r  <= '0;
            in_sb_r    <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            pending    <= pend_n;
            ready_r    <= 1'b1;
            frame_err  <= err_c;
            in_valid_r <= accept;
            in_real_r  <= source_real;
            in_imag_r  <= source_imag;
            in_sb_r    <= {first_c, last_c, bin_c};
        end
    end

    fft_mag_sq #(
        .DATA_W (DATA_W),
        .SB_W   (SB_W)
    ) u_mag_sq (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_r),
        .in_real   (in_real_r),
        .in_imag   (in_imag_r),
        .in_sb     (in_sb_r),
        .out_valid (mq_valid),
        .out_mag   (mq_mag),
        .out_sb    (mq_sb)
    );

    assign mq_first = mq_sb[IDX_W+1];
    assign mq_last  = mq_sb[IDX_W];
    assign mq_idx   = mq_sb[IDX_W-1:0];

    // Bin 0 of a frame restarts the search, so bins of a following frame
    // never mix into the result still waiting to be reported.
    always_comb begin
        if (mq_first) begin
            base_mag = '0;
            base_idx = LO_BIN;
        end else begin
            base_mag = max_mag;
            base_idx = max_idx;
        end
        cand_mag = base_mag;
        cand_idx = base_idx;
        if ((mq_idx >= LO_BIN) && (mq_idx <= HI_BIN) && (mq_mag > base_mag)) begin
            cand_mag = mq_mag;
            cand_idx = mq_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_mag    <= '0;
            max_idx    <= LO_BIN;
            last_r     <= 1'b0;
            peak_valid <= 1'b0;
            peak_idx   <= '0;
            peak_mag   <= '0;
        end else begin
            if (mq_valid) begin
                max_mag <= cand_mag;
                max_idx <= cand_idx;
            end
            last_r     <= mq_valid && mq_last;
            peak_valid <= last_r;
            if (last_r) begin
                peak_idx <= max_idx;
                peak_mag <= max_mag;
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed bench for fft_peak_detect with a 16-bin frame.
module tb_fft_peak_detect;

    logic               clk;
    logic               rst_n;
    logic               source_valid;
    logic               source_sop;
    logic               source_eop;
    logic signed [15:0] source_real;
    logic signed [15:0] source_imag;
    logic               source_ready;
    logic [3:0]         peak_idx;
    logic [32:0]        peak_mag;
    logic               peak_valid;
    logic               frame_err;

    fft_peak_detect #(
        .DATA_W    (16),
        .FRAME_LEN (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .source_valid (source_valid),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .source_real  (source_real),
        .source_imag  (source_imag),
        .source_ready (source_ready),
        .peak_idx     (peak_idx),
        .peak_mag     (peak_mag),
        .peak_valid   (peak_valid),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;
    int eop_cyc = 0;
    int beat_cyc = 0;
    int fe_count = 0;
    int fe_cyc = 0;
    logic [3:0]  pv_idx_q[$];
    logic [32:0] pv_mag_q[$];
    int          pv_cyc_q[$];
    logic signed [15:0] fr_re [16];
    logic signed [15:0] fr_im [16];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (peak_valid) begin
                pv_idx_q.push_back(peak_idx);
                pv_mag_q.push_back(peak_mag);
                pv_cyc_q.push_back(cyc);
            end
            if (frame_err) begin
                fe_count++;
                fe_cyc = cyc;
            end
        end
    end

    task automatic clear_frame();
        for (int i = 0; i < 16; i++) begin
            fr_re[i] = '0;
            fr_im[i] = '0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            source_valid = 1'b0;
            source_sop   = 1'b0;
            source_eop   = 1'b0;
        end
    endtask

    task automatic beat(input logic sop, input logic eop,
                        input logic signed [15:0] re, input logic signed [15:0] im);
        @(negedge clk);
        source_valid = 1'b1;
        source_sop   = sop;
        source_eop   = eop;
        source_real  = re;
        source_imag  = im;
        beat_cyc     = cyc + 1;
        if (eop) eop_cyc = cyc + 1;
    endtask

    task automatic send_frame(input bit gaps);
        for (int i = 0; i < 16; i++) begin
            if (gaps) idle($urandom_range(0, 2));
            beat(i == 0, i == 15, fr_re[i], fr_im[i]);
        end
    endtask

    task automatic wait_reports(input int target);
        int k = 0;
        while (pv_idx_q.size() < target && k < 60) begin
            @(negedge clk);
            #1;
            k++;
        end
        vecs++;
        if (pv_idx_q.size() < target) begin
            errs++;
            $display("FAIL report_timeout: got %0d reports, need %0d", pv_idx_q.size(), target);
        end
    endtask

    task automatic check_last_report(input string name, input logic [3:0] idx,
                                     input logic [32:0] mag);
        vecs++;
        if (pv_idx_q.size() == 0 || pv_idx_q[$] !== idx) begin
            errs++;
            $display("FAIL %s_idx: got %0d want %0d", name, pv_idx_q.size() ? pv_idx_q[$] : 4'd0, idx);
        end
        vecs++;
        if (pv_mag_q.size() == 0 || pv_mag_q[$] !== mag) begin
            errs++;
            $display("FAIL %s_mag: got %0d want %0d", name, pv_mag_q.size() ? pv_mag_q[$] : 33'd0, mag);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0;
        source_real = '0; source_imag = '0;
        repeat (3) @(negedge clk);
        vecs++; if (source_ready !== 1'b0) begin errs++; $display("FAIL reset_ready: got %b want 0", source_ready); end
        vecs++; if (peak_idx !== 4'd0) begin errs++; $display("FAIL reset_peak_idx: got %0d want 0", peak_idx); end
        vecs++; if (peak_mag !== 33'd0) begin errs++; $display("FAIL reset_peak_mag: got %0d want 0", peak_mag); end
        vecs++; if (peak_valid !== 1'b0) begin errs++; $display("FAIL reset_peak_valid: got %b want 0", peak_valid); end
        vecs++; if (frame_err !== 1'b0) begin errs++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        rst_n = 1'b1;
        #1;
        vecs++; if (source_ready !== 1'b0) begin errs++; $display("FAIL ready_before_clock: got %b want 0", source_ready); end
        @(posedge clk); #1;
        vecs++; if (source_ready !== 1'b1) begin errs++; $display("FAIL ready_after_clock: got %b want 1", source_ready); end
    endtask

    task automatic test_single_peak();
        int base = pv_idx_q.size();
        int fe0 = fe_count;
        clear_frame();
        fr_re[5] = 16'sd3; fr_im[5] = 16'sd4;
        send_frame(1'b0);
        idle(1);
        wait_reports(base + 1);
        check_last_report("single", 4'd5, 33'd25);
        vecs++;
        if (pv_cyc_q.size() == 0 || pv_cyc_q[$] - eop_cyc != 4) begin
            errs++;
            $display("FAIL single_latency: got %0d want 4", pv_cyc_q.size() ? pv_cyc_q[$] - eop_cyc : -1);
        end
        idle(6);
        vecs++; if (pv_idx_q.size() != base + 1) begin errs++; $display("FAIL single_pulse_count: got %0d want %0d", pv_idx_q.size(), base + 1); end
        vecs++; if (fe_count != fe0) begin errs++; $display("FAIL single_no_err: got %0d want %0d", fe_count, fe0); end
    endtask

    task automatic test_extreme_tie();
        int base = pv_idx_q.size();
        clear_frame();
        fr_re[3] = -16'sd32768;
        fr_re[6] = -16'sd32768;
        send_frame(1'b0);
        idle(1);
        wait_reports(base + 1);
        check_last_report("tie_extreme", 4'd3, 33'd1073741824);
    endtask

    task automatic test_window_bounds();
        int base = pv_idx_q.size();
        clear_frame();
        fr_re[0] = 16'sd1000;
        fr_re[2] = 16'sd10;
        fr_re[8] = 16'sd500;
        fr_im[15] = 16'sd700;
        send_frame(1'b0);
        idle(1);
        wait_reports(base + 1);
        check_last_report("dc_excluded", 4'd2, 33'd100);
        clear_frame();
        send_frame(1'b0);
        idle(1);
        wait_reports(base + 2);
        check_last_report("all_zero", 4'd1, 33'd0);
    endtask

    task automatic test_early_eop();
        int base = pv_idx_q.size();
        int fe0 = fe_count;
        for (int i = 0; i < 9; i++) beat(i == 0, 1'b0, 16'sd0, 16'sd0);
        beat(1'b0, 1'b1, 16'sd0, 16'sd0);
        idle(1);
        #1;
        vecs++; if (fe_count != fe0 + 1) begin errs++; $display("FAIL early_eop_err: got %0d want %0d", fe_count, fe0 + 1); end
        vecs++; if (fe_cyc != beat_cyc) begin errs++; $display("FAIL early_eop_err_cycle: got %0d want %0d", fe_cyc, beat_cyc); end
        idle(8);
        vecs++; if (fe_count != fe0 + 1) begin errs++; $display("FAIL early_eop_err_width: got %0d want %0d", fe_count, fe0 + 1); end
        vecs++; if (pv_idx_q.size() != base) begin errs++; $display("FAIL early_eop_no_report: got %0d want %0d", pv_idx_q.size(), base); end
        clear_frame();
        fr_im[4] = -16'sd7;
        send_frame(1'b0);
        idle(1);
        wait_reports(base + 1);
        check_last_report("after_early_eop", 4'd4, 33'd49);
    endtask

    task automatic test_mid_sop();
        int base = pv_idx_q.size();
        int fe0 = fe_count;
        for (int i = 0; i < 7; i++)
            beat(i == 0, 1'b0, (i == 3) ? 16'sd100 : 16'sd0, (i == 3) ? 16'sd100 : 16'sd0);
        clear_frame();
        fr_re[6] = 16'sd5; fr_im[6] = 16'sd5;
        send_frame(1'b0);
        idle(1);
        wait_reports(base + 1);
        idle(8);
        vecs++; if (fe_count != fe0 + 1) begin errs++; $display("FAIL mid_sop_err_count: got %0d want %0d", fe_count, fe0 + 1); end
        vecs++; if (pv_idx_q.size() != base + 1) begin errs++; $display("FAIL mid_sop_report_count: got %0d want %0d", pv_idx_q.size(), base + 1); end
        check_last_report("mid_sop", 4'd6, 33'd50);
    endtask

    task automatic test_back_to_back();
        int base = pv_idx_q.size();
        int fe0 = fe_count;
        clear_frame();
        fr_re[5] = 16'sd3; fr_im[5] = 16'sd4;
        send_frame(1'b0);
        clear_frame();
        fr_re[1] = 16'sd100;
        send_frame(1'b0);
        idle(1);
        wait_reports(base + 2);
        vecs++;
        if (pv_idx_q.size() < base + 2 || pv_idx_q[base] !== 4'd5 || pv_mag_q[base] !== 33'd25) begin
            errs++;
            $display("FAIL b2b_first: got %0d/%0d want 5/25",
                     pv_idx_q.size() > base ? pv_idx_q[base] : 4'd0,
                     pv_mag_q.size() > base ? pv_mag_q[base] : 33'd0);
        end
        check_last_report("b2b_second", 4'd1, 33'd10000);
        vecs++;
        if (pv_cyc_q.size() == 0 || pv_cyc_q[$] - eop_cyc != 4) begin
            errs++;
            $display("FAIL b2b_latency: got %0d want 4", pv_cyc_q.size() ? pv_cyc_q[$] - eop_cyc : -1);
        end
        vecs++; if (fe_count != fe0) begin errs++; $display("FAIL b2b_no_err: got %0d want %0d", fe_count, fe0); end
    endtask

    task automatic test_gaps_reset();
        int base = pv_idx_q.size();
        int fe0 = fe_count;
        clear_frame();
        fr_re[7] = -16'sd3; fr_im[7] = -16'sd4;
        send_frame(1'b1);
        clear_frame();
        fr_im[1] = 16'sd2;
        fr_re[8] = 16'sd50;
        send_frame(1'b1);
        idle(1);
        wait_reports(base + 2);
        vecs++;
        if (pv_idx_q.size() < base + 2 || pv_idx_q[base] !== 4'd7 || pv_mag_q[base] !== 33'd25) begin
            errs++;
            $display("FAIL gaps_first: got %0d/%0d want 7/25",
                     pv_idx_q.size() > base ? pv_idx_q[base] : 4'd0,
                     pv_mag_q.size() > base ? pv_mag_q[base] : 33'd0);
        end
        check_last_report("gaps_second", 4'd1, 33'd4);
        clear_frame();
        fr_re[2] = 16'sd9;
        for (int i = 0; i < 6; i++) beat(i == 0, 1'b0, fr_re[i], fr_im[i]);
        #2 rst_n = 1'b0;
        #1;
        vecs++; if (peak_idx !== 4'd0) begin errs++; $display("FAIL midreset_peak_idx: got %0d want 0", peak_idx); end
        vecs++; if (peak_mag !== 33'd0) begin errs++; $display("FAIL midreset_peak_mag: got %0d want 0", peak_mag); end
        vecs++; if (peak_valid !== 1'b0) begin errs++; $display("FAIL midreset_peak_valid: got %b want 0", peak_valid); end
        vecs++; if (source_ready !== 1'b0) begin errs++; $display("FAIL midreset_ready: got %b want 0", source_ready); end
        idle(2);
        rst_n = 1'b1;
        for (int i = 6; i < 16; i++) beat(1'b0, i == 15, fr_re[i], fr_im[i]);
        idle(12);
        vecs++; if (pv_idx_q.size() != base + 2) begin errs++; $display("FAIL midreset_no_report: got %0d want %0d", pv_idx_q.size(), base + 2); end
        vecs++; if (fe_count != fe0) begin errs++; $display("FAIL midreset_no_err: got %0d want %0d", fe_count, fe0); end
        vecs++; if (peak_mag !== 33'd0) begin errs++; $display("FAIL midreset_mag_held: got %0d want 0", peak_mag); end
    endtask

    initial begin
        test_reset();
        test_single_peak();
        test_extreme_tie();
        test_window_bounds();
        test_early_eop();
        test_mid_sop();
        test_back_to_back();
        test_gaps_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
